// File: rtl/xoodoo_pkg.sv
// Shared types and constants for the Xoodoo permutation engine.
// The RC table is ordered so a reduced-round run uses its last NUM_ROUNDS entries.
package xoodoo_pkg;

  localparam int unsigned LANE_W    = 32;
  localparam int unsigned NUM_LANES = 12;
  localparam int unsigned STATE_W   = LANE_W * NUM_LANES;

  typedef logic [LANE_W-1:0] lane_t;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } fsm_state_e;

  localparam lane_t RC [NUM_LANES] = '{
    32'h0000_0058, 32'h0000_0038, 32'h0000_03C0, 32'h0000_00D0,
    32'h0000_0120, 32'h0000_0014, 32'h0000_0060, 32'h0000_002C,
    32'h0000_0380, 32'h0000_00F0, 32'h0000_01A0, 32'h0000_0012
  };

  function automatic lane_t rc_lookup(input logic [3:0] idx);
    lane_t val;
    val = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (idx == 4'(i)) val = RC[i];
    end
    return val;
  endfunction

  function automatic lane_t rotl(input lane_t v, input int unsigned n);
    return (v << n) | (v >> (LANE_W - n));
  endfunction

endpackage

// File: rtl/xoodoo_round.sv
// One combinational Xoodoo round: theta, rho-west, iota, chi, rho-east.
// Lane i = bits [32*i+31:32*i]; plane y holds lanes 4y..4y+3 with x = i % 4.
module xoodoo_round
  import xoodoo_pkg::*;
(
  input  logic [STATE_W-1:0] a_in,
  input  logic [LANE_W-1:0]  rc,
  output logic [STATE_W-1:0] a_out
);

  lane_t a [3][4];
  lane_t t [3][4];
  lane_t w [3][4];
  lane_t c [3][4];
  lane_t p [4];
  lane_t e [4];

  always_comb begin
    a_out = '0;
    for (int unsigned y = 0; y < 3; y++) begin
      for (int unsigned x = 0; x < 4; x++) begin
        a[y][x] = a_in[LANE_W*(4*y+x) +: LANE_W];
      end
    end

    for (int unsigned x = 0; x < 4; x++) begin
      p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
    end
    for (int unsigned x = 0; x < 4; x++) begin
      e[x] = rotl(p[(x+3)%4], 5) ^ rotl(p[(x+3)%4], 14);
    end
    for (int unsigned y = 0; y < 3; y++) begin
      for (int unsigned x = 0; x < 4; x++) begin
        t[y][x] = a[y][x] ^ e[x];
      end
    end

    for (int unsigned x = 0; x < 4; x++) begin
      w[0][x] = t[0][x];
      w[1][x] = t[1][(x+3)%4];
      w[2][x] = rotl(t[2][x], 11);
    end
    w[0][0] = w[0][0] ^ rc;

    // chi reads only the pre-chi planes, so every plane sees the same inputs
    for (int unsigned y = 0; y < 3; y++) begin
      for (int unsigned x = 0; x < 4; x++) begin
        c[y][x] = w[y][x] ^ (~w[(y+1)%3][x] & w[(y+2)%3][x]);
      end
    end

    for (int unsigned x = 0; x < 4; x++) begin
      a_out[LANE_W*x       +: LANE_W] = c[0][x];
      a_out[LANE_W*(4+x)   +: LANE_W] = rotl(c[1][x], 1);
      a_out[LANE_W*(8+x)   +: LANE_W] = rotl(c[2][(x+2)%4], 8);
    end
  end

endmodule

// File: rtl/xoodoo_permutation.sv
// Iterative Xoodoo[NUM_ROUNDS] engine: captures state on start, applies UNROLL rounds
// per clock, and publishes the result with a single-cycle done pulse.
module xoodoo_permutation
  import xoodoo_pkg::*;
#(
  parameter int NUM_ROUNDS = 12,
  parameter int UNROLL     = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [STATE_W-1:0] state_in,
  output logic [STATE_W-1:0] state_out,
  output logic               done,
  output logic               busy
);

  localparam int unsigned ROUND_OFS = NUM_LANES - NUM_ROUNDS;

  fsm_state_e         state_q, state_d;
  logic [3:0]         rnd_q, rnd_d;
  logic [STATE_W-1:0] work_q, work_d;
  logic [STATE_W-1:0] state_out_d;
  logic               done_d;
  logic [3:0]         rnd_step;
  logic               last_step;

  logic [STATE_W-1:0] chain [UNROLL+1];
  lane_t              rc_sel [UNROLL];

  assign chain[0] = work_q;

  // Stage g of the chain executes round rnd_q+g of the current run
  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    assign rc_sel[g] = rc_lookup(4'(ROUND_OFS) + rnd_q + 4'(g));

    xoodoo_round u_round (
      .a_in  (chain[g]),
      .rc    (rc_sel[g]),
      .a_out (chain[g+1])
    );
  end

  assign rnd_step  = rnd_q + 4'(UNROLL);
  assign last_step = (rnd_step == 4'(NUM_ROUNDS));
  assign busy      = (state_q == S_RUN);

  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    work_d      = work_q;
    state_out_d = state_out;
    done_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          rnd_d   = '0;
          work_d  = state_in;
        end
      end
      S_RUN: begin
        work_d = chain[UNROLL];
        if (last_step) begin
          state_d     = S_IDLE;
          rnd_d       = '0;
          state_out_d = chain[UNROLL];
          done_d      = 1'b1;
        end else begin
          rnd_d = rnd_step;
        end
      end
      default: begin
        state_d = S_IDLE;
        rnd_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rnd_q     <= '0;
      work_q    <= '0;
      state_out <= '0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rnd_q     <= rnd_d;
      work_q    <= work_d;
      state_out <= state_out_d;
      done      <= done_d;
    end
  end

endmodule
